i2c_master_burst: RTL and testbench

//  Parametrised I2C master: 7-bit addressing, multi-byte write/read bursts, programmable SCL rate.

---
 rtl/i2c_master_burst_if.sv | 31 +++
 rtl/i2c_master_burst.sv | 246 ++++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_burst_if.sv
// Host command/stream and pad signals of the burst I2C master, grouped as one bundle.
// The master modport is the controller block; the slave modport is the host plus pad side.
interface i2c_master_burst_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic [6:0]       addr_in;
    logic             write;
    logic [LEN_W-1:0] len_in;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             sda_in;
    logic             i2c_sda_out;
    logic             i2c_scl_out;
    logic             busy;
    logic             done;
    logic             nack_err;

    modport master (
        input  start, addr_in, write, len_in, wr_data, wr_valid, sda_in,
        output wr_ready, rd_data, rd_valid, i2c_sda_out, i2c_scl_out, busy, done, nack_err
    );

    modport slave (
        output start, addr_in, write, len_in, wr_data, wr_valid, sda_in,
        input  wr_ready, rd_data, rd_valid, i2c_sda_out, i2c_scl_out, busy, done, nack_err
    );
endinterface

// File: rtl/i2c_master_burst.sv
// I2C master with 7-bit address, write/read bursts, slave-NACK abort; frame = 4*CLK_DIV*(2+9*(1+len)) clocks.
// Write data stalls the bus with SCL held low in P0 until wr_valid; reads are never backpressured.
module i2c_master_burst #(
    parameter int CLK_DIV = 125,
    parameter int LEN_W   = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    i2c_master_burst_if.master    bus
);

    localparam int             QW   = $clog2(CLK_DIV);
    localparam logic [QW-1:0]  QMAX = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RACK,
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [QW-1:0]    qcnt;
    logic [1:0]       phase;
    logic [2:0]       bitcnt;
    logic [LEN_W-1:0] bytecnt;
    logic [7:0]       shreg;
    logic             write_q;
    logic             have_byte;
    logic             ack_smp;
    logic             done_q;
    logic             nack_q;
    logic             rd_valid_q;
    logic [7:0]       rd_data_q;

    logic             tick;
    logic             wr_ready_c;
    logic             stall;
    logic             p_end;
    logic             cell_end;
    logic             sample;
    logic             xfer;
    logic             scl_c;
    logic             sda_c;

    assign tick       = (qcnt == QMAX);
    assign wr_ready_c = (state == S_WDATA) && !have_byte;
    assign stall      = wr_ready_c && !bus.wr_valid;
    assign p_end      = tick && !stall;
    assign cell_end   = p_end && (phase == 2'd3);
    assign sample     = p_end && (phase == 2'd2);
    assign xfer       = wr_ready_c && bus.wr_valid;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_c     = 1'b1;
        sda_c     = 1'b1;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                sda_c = !phase[1];
                if (cell_end) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                scl_c = phase[1];
                sda_c = shreg[7];
                if (cell_end && bitcnt == 3'd7) begin
                    state_nxt = S_AACK;
                end
            end
            S_AACK: begin
                scl_c = phase[1];
                if (cell_end) begin
                    if (ack_smp || bytecnt == '0) begin
                        state_nxt = S_STOP;
                    end else if (write_q) begin
                        state_nxt = S_WDATA;
                    end else begin
                        state_nxt = S_RDATA;
                    end
                end
            end
            S_WDATA: begin
                // SDA stays released until the byte is in hand; SCL is low so this is not a bus event.
                scl_c = phase[1];
                sda_c = have_byte ? shreg[7] : 1'b1;
                if (cell_end && bitcnt == 3'd7) begin
                    state_nxt = S_WACK;
                end
            end
            S_WACK: begin
                scl_c = phase[1];
                if (cell_end) begin
                    if (ack_smp || bytecnt == LEN_W'(1)) begin
                        state_nxt = S_STOP;
                    end else begin
                        state_nxt = S_WDATA;
                    end
                end
            end
            S_RDATA: begin
                scl_c = phase[1];
                if (cell_end && bitcnt == 3'd7) begin
                    state_nxt = S_RACK;
                end
            end
            S_RACK: begin
                scl_c = phase[1];
                sda_c = (bytecnt == LEN_W'(1));
                if (cell_end) begin
                    if (bytecnt == LEN_W'(1)) begin
                        state_nxt = S_STOP;
                    end else begin
                        state_nxt = S_RDATA;
                    end
                end
            end
            S_STOP: begin
                scl_c = phase[1];
                sda_c = (phase == 2'd3);
                if (cell_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            qcnt       <= '0;
            phase      <= 2'd0;
            bitcnt     <= 3'd0;
            bytecnt    <= '0;
            shreg      <= 8'd0;
            write_q    <= 1'b0;
            have_byte  <= 1'b0;
            ack_smp    <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            if (state == S_IDLE) begin
                qcnt   <= '0;
                phase  <= 2'd0;
                bitcnt <= 3'd0;
                if (bus.start) begin
                    write_q   <= bus.write;
                    bytecnt   <= bus.len_in;
                    shreg     <= {bus.addr_in, ~bus.write};
                    have_byte <= 1'b0;
                    nack_q    <= 1'b0;
                end
            end else begin
                if (!stall) begin
                    qcnt <= tick ? '0 : qcnt + QW'(1);
                end
                if (p_end) begin
                    phase <= phase + 2'd1;
                end
                if (sample) begin
                    ack_smp <= bus.sda_in;
                    if (state == S_RDATA) begin
                        shreg <= {shreg[6:0], bus.sda_in};
                        if (bitcnt == 3'd7) begin
                            rd_data_q  <= {shreg[6:0], bus.sda_in};
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                if (xfer) begin
                    shreg     <= bus.wr_data;
                    have_byte <= 1'b1;
                end
                if (cell_end) begin
                    case (state)
                        S_ADDR, S_WDATA: begin
                            shreg  <= {shreg[6:0], 1'b0};
                            bitcnt <= bitcnt + 3'd1;
                        end
                        S_RDATA: begin
                            bitcnt <= bitcnt + 3'd1;
                        end
                        S_AACK: begin
                            have_byte <= 1'b0;
                            if (ack_smp) begin
                                nack_q <= 1'b1;
                            end
                        end
                        S_WACK: begin
                            have_byte <= 1'b0;
                            bytecnt   <= bytecnt - LEN_W'(1);
                            if (ack_smp) begin
                                nack_q <= 1'b1;
                            end
                        end
                        S_RACK: begin
                            bytecnt <= bytecnt - LEN_W'(1);
                        end
                        S_STOP: begin
                            done_q <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign bus.i2c_scl_out = scl_c;
    assign bus.i2c_sda_out = sda_c;
    assign bus.wr_ready    = wr_ready_c;
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = done_q;
    assign bus.nack_err    = nack_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: a behavioural I2C slave on the wired-AND SDA line, a write-data host,
// and a transaction-level model of the expected bus bytes, read data, ACKs and frame length.
module tb_i2c_master_burst;

    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 4;
    localparam int CELL    = 4 * CLK_DIV;

    logic clk = 1'b0;
    logic rst;
    logic slave_drv;

    always #5 clk = ~clk;

    i2c_master_burst_if #(.LEN_W(LEN_W)) bus ();
    assign bus.sda_in = bus.i2c_sda_out & slave_drv;

    i2c_master_burst #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // slave model state
    logic       scl_p, sda_p, rw, slave_active;
    int         bitpos, byte_no;
    logic [7:0] cur;
    int         cfg_len, cfg_nack_byte;
    logic       cfg_nack_addr;
    logic [7:0] wbytes [16];
    logic [7:0] rbytes [16];

    // host and monitor state
    logic       ready_p;
    int         stall_left, widx;
    int         n_done, n_busy, n_hs, n_stop, n_sclbad;
    logic [7:0] bus_q [$];
    logic       mack_q [$];
    logic [7:0] rd_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic slave_reset();
        bitpos       = -1;
        byte_no      = 0;
        rw           = 1'b0;
        cur          = 8'd0;
        slave_active = 1'b0;
        slave_drv    = 1'b1;
        scl_p        = 1'b1;
        sda_p        = 1'b1;
    endtask

    task automatic clear_counts();
        n_done = 0; n_busy = 0; n_hs = 0; n_stop = 0; n_sclbad = 0;
        bus_q.delete(); mack_q.delete(); rd_q.delete();
    endtask

    // One clock: observe the bus at the falling clock edge, react as slave and host, then tally.
    task automatic step();
        logic scl, sda;
        @(negedge clk);
        scl = bus.i2c_scl_out;
        sda = bus.i2c_sda_out & slave_drv;
        if (scl_p && scl && sda_p && !sda) begin
            bitpos = -1; byte_no = 0; cur = 8'd0; slave_active = 1'b1;
        end else if (scl_p && scl && !sda_p && sda) begin
            n_stop++;
        end else if (!scl_p && scl) begin
            if (bitpos >= 0 && bitpos < 8) begin
                cur = {cur[6:0], sda};
            end else if (bitpos == 8) begin
                if (byte_no == 0) rw = cur[0];
                if (byte_no == 0 || !rw) bus_q.push_back(cur);
                else begin
                    mack_q.push_back(sda);
                    if (sda) slave_active = 1'b0;
                end
            end
        end else if (scl_p && !scl) begin
            bitpos++;
            if (bitpos == 9) begin
                bitpos = 0;
                byte_no++;
            end
            slave_drv = 1'b1;
            if (slave_active) begin
                if (bitpos == 8 && (byte_no == 0 || !rw)) begin
                    if ((byte_no == 0 && cfg_nack_addr) || (byte_no != 0 && byte_no == cfg_nack_byte))
                        slave_active = 1'b0;
                    else
                        slave_drv = 1'b0;
                end else if (bitpos < 8 && byte_no > 0 && rw && byte_no <= cfg_len) begin
                    slave_drv = rbytes[byte_no-1][7-bitpos];
                end
            end
        end
        scl_p = scl;
        sda_p = bus.i2c_sda_out & slave_drv;

        if (bus.wr_ready) begin
            if (stall_left > 0) begin
                bus.wr_valid = 1'b0;
                stall_left--;
            end else begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = wbytes[widx & 15];
            end
        end else begin
            if (ready_p) begin
                n_hs++;
                widx++;
            end
            bus.wr_valid = 1'b0;
        end
        ready_p = bus.wr_ready;

        if (bus.busy) n_busy++;
        if (bus.done) n_done++;
        if (bus.rd_valid) rd_q.push_back(bus.rd_data);
        if (bus.wr_ready && bus.i2c_scl_out) n_sclbad++;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic wr, input int len, input logic na,
                           input int nb, input int stall, input logic poke);
        logic [7:0] exp_b [$];
        int   nbytes, frame, cyc, exp_rd;
        logic exp_nack;

        cfg_len = len; cfg_nack_addr = na; cfg_nack_byte = wr ? nb : 0;
        stall_left = stall; widx = 0;
        clear_counts();

        // Reference: bytes seen on the bus, bytes actually completed, and the resulting frame time.
        exp_b.push_back({a, ~wr});
        if (!na && wr) begin
            for (int i = 0; i < len; i++) begin
                exp_b.push_back(wbytes[i]);
                if (nb == i + 1) break;
            end
        end
        nbytes   = na ? 0 : ((wr && nb != 0) ? nb : len);
        frame    = CELL * (2 + 9 * (1 + nbytes)) + stall;
        exp_nack = na || (wr && nb != 0);
        exp_rd   = (!wr && !na) ? len : 0;

        bus.addr_in = a; bus.write = wr; bus.len_in = LEN_W'(len); bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("accept_busy", bus.busy, 1);
        chk("accept_nack_clr", bus.nack_err, 0);
        cyc = 0;
        while (n_done == 0 && cyc < 20000) begin
            bus.start = poke && cyc >= 40 && cyc < 43;
            if (poke) bus.addr_in = 7'h11;
            step();
            cyc++;
        end
        bus.start = 1'b0;
        chk("done_seen", n_done, 1);
        chk("nack_err", bus.nack_err, exp_nack);
        repeat (6) step();
        chk("done_once", n_done, 1);
        chk("frame_len", n_busy, frame);
        chk("idle_after", bus.busy, 0);
        chk("nack_hold", bus.nack_err, exp_nack);
        chk("stop_cnt", n_stop, 1);
        chk("bus_cnt", bus_q.size(), exp_b.size());
        foreach (exp_b[i]) chk("bus_byte", (i < bus_q.size()) ? 32'(bus_q[i]) : 32'hFFFF_FFFF, exp_b[i]);
        chk("wr_hs", n_hs, wr ? nbytes : 0);
        chk("rd_cnt", rd_q.size(), exp_rd);
        chk("mack_cnt", mack_q.size(), exp_rd);
        for (int i = 0; i < exp_rd; i++) begin
            chk("rd_byte", (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF_FFFF, rbytes[i]);
            chk("master_ack", (i < mack_q.size()) ? 32'(mack_q[i]) : 32'hFFFF_FFFF, (i == exp_rd - 1) ? 1 : 0);
        end
        chk("scl_low_in_stall", n_sclbad, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus.start = 1'b0; bus.addr_in = 7'd0; bus.write = 1'b0; bus.len_in = '0;
        bus.wr_data = 8'd0; bus.wr_valid = 1'b0;
        slave_reset();
        ready_p = 1'b0; stall_left = 0; widx = 0;
        cfg_len = 0; cfg_nack_addr = 1'b0; cfg_nack_byte = 0;
        clear_counts();
        repeat (3) step();
        chk("rst_scl", bus.i2c_scl_out, 1);
        chk("rst_sda", bus.i2c_sda_out, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_nack", bus.nack_err, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        rst = 1'b0;
        step();

        wbytes[0] = 8'h12; wbytes[1] = 8'h34;
        run_txn(7'h50, 1'b1, 2, 1'b0, 0, 0, 1'b0);

        rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33;
        run_txn(7'h68, 1'b0, 3, 1'b0, 0, 0, 1'b0);

        run_txn(7'h2A, 1'b1, 2, 1'b1, 0, 0, 1'b0);
        repeat (20) step();
        chk("nack_held_idle", bus.nack_err, 1);

        wbytes[0] = 8'hA5;
        run_txn(7'h21, 1'b1, 1, 1'b0, 0, 50, 1'b0);

        run_txn(7'h3C, 1'b1, 0, 1'b0, 0, 0, 1'b1);

        // Reset in the middle of the second data byte.
        wbytes[0] = 8'hC3; wbytes[1] = 8'h5A; wbytes[2] = 8'h0F;
        cfg_len = 3; cfg_nack_addr = 1'b0; cfg_nack_byte = 0; stall_left = 0; widx = 0;
        clear_counts();
        bus.addr_in = 7'h33; bus.write = 1'b1; bus.len_in = LEN_W'(3); bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus_q.size() >= 2 && bitpos >= 3) && cyc < 5000) begin
            step();
            cyc++;
        end
        chk("rst_mid_reached", (bus_q.size() >= 2) ? 1 : 0, 1);
        rst = 1'b1;
        step();
        chk("rst_mid_scl", bus.i2c_scl_out, 1);
        chk("rst_mid_sda", bus.i2c_sda_out, 1);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_wr_ready", bus.wr_ready, 0);
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        slave_reset();
        ready_p = 1'b0;
        step();
        run_txn(7'h33, 1'b1, 3, 1'b0, 0, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            logic [6:0] a;
            logic       wr, na;
            int         len, nb;
            a   = 7'($urandom_range(0, 127));
            wr  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 6);
            na  = ($urandom_range(0, 7) == 0);
            nb  = (wr && len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            for (int i = 0; i < 16; i++) begin
                wbytes[i] = 8'($urandom_range(0, 255));
                rbytes[i] = 8'($urandom_range(0, 255));
            end
            run_txn(a, wr, len, na, nb, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
